serial_comparator: RTL and testbench
====================================

# serial_comparator

Bit-serial, MSB-first magnitude comparator with selectable signed/unsigned mode. It consumes two operands one bit per clock and reports whether a is greater than b. It is the serial counterpart of the team's parallel signed/unsigned comparator. It sits behind shift-register or serial-link datapaths where the full operand words are never available in parallel.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a comparison; honoured only while ready = 1.
- mode  input  1  1 = two's-complement signed compare, 0 = unsigned; sampled with start.
- a_bit  input  1  serial bit of operand a, MSB first.
- b_bit  input  1  serial bit of operand b, MSB first.
- ready  output  1  block idle and able to accept start.
- done_tick  output  1  one-cycle pulse when agtb holds a new result.
- agtb  output  1  result: 1 when a > b under the latched mode; held until the next done_tick.
- aeqb  output  1  1 when a == b; present only with SERIAL_CMP_EQ_EN.

## Operation
- States:
  - IDLE: ready = 1. If start = 1, the block latches mode, processes the first bit pair (bit WIDTH-1) on that edge, loads the counter with WIDTH-2, and moves to SHIFT.
  - SHIFT: processes one bit pair per clock. If the counter is 0 on the edge, the block moves to DONE; otherwise it decrements the counter.
  - DONE: done_tick = 1 for one cycle, agtb (and aeqb) update on entry, then the block returns to IDLE.
- Decision registers: decided (1 bit) and gt (1 bit). Both clear when start is accepted.
- Per bit, while decided = 0:
  - If a_bit != b_bit: set decided = 1 and set gt = a_bit.
  - Exception for the MSB (first bit) when latched mode = 1: set gt = b_bit. This matches the rule that a positive operand beats a negative one.
- Once decided = 1, later bits are ignored.
- Equal operands give gt = 0 (agtb = 0).
- agtb is a register loaded from gt on the edge that enters DONE.
- The mode input and start are ignored outside IDLE. The latched mode governs the whole operation.
- The counter is $clog2(WIDTH) bits wide and counts down. No wrap occurs because the block exits SHIFT at 0.

## Timing
- Cycle 0: start = 1 in IDLE, with a_bit/b_bit = bit WIDTH-1.
- Cycles 1..WIDTH-1: bits WIDTH-2..0 are presented.
- Cycle WIDTH: done_tick = 1 and agtb is valid (already updated at the end of cycle WIDTH-1).
- Cycle WIDTH+1: ready = 1 and a new start is accepted. Throughput is one compare per WIDTH+1 cycles.
- ready is decoded from state: high in IDLE only, including while reset_n = 0.
- Reset values: state IDLE, done_tick = 0, agtb = 0, aeqb = 0, decided = 0, gt = 0, counter = 0.
- Reset mid-operation: the block aborts immediately, the previous agtb clears to 0, and no done_tick is issued.
- If start is held high across DONE, the next compare begins at cycle WIDTH+1. Bit WIDTH-1 must be presented in that cycle.

## Configuration
- SERIAL_CMP_EQ_EN defined:
  - Adds the aeqb output port.
  - aeqb is loaded at the same edge as agtb with the value (decided == 0), and holds until the next result.
  - Reset value is 0.
- SERIAL_CMP_EQ_EN undefined:
  - No aeqb port and no extra logic.
  - Equal operands are reported only as agtb = 0.

## Test plan
- WIDTH=8, mode=0, a=0x80, b=0x7F, start at cycle 0 -> done_tick at cycle 8, agtb=1; ready back high at cycle 9.
- WIDTH=8, mode=1, a=0x80 (-128), b=0x7F (127) -> agtb=0 at done_tick.
- WIDTH=8, mode=1, a=0xFE (-2), b=0xFD (-3) -> agtb=1. Repeat with mode=0 -> agtb=1. Repeat with a and b swapped -> agtb=0.
- a=b=0x5A, both modes -> agtb=0. With SERIAL_CMP_EQ_EN, aeqb=1. Follow with a=0x5B, b=0x5A -> agtb=1, aeqb=0.
- Mid-operation interference: pulse start and toggle mode at cycle 3 of a mode=0 compare of a=0x01, b=0xFF. Required: the pulse is ignored, done_tick comes exactly once at cycle 8, and agtb=0.
- Assert reset_n=0 at cycle 4 of a compare after a prior result with agtb=1. Required: agtb=0 and ready=1 immediately, and no done_tick. A fresh compare after release completes normally.

Source files
------------

// File: rtl/serial_comparator.sv
// Bit-serial MSB-first magnitude comparator (a > b), signed or unsigned per compare.
// Optional equality output is enabled by defining SERIAL_CMP_EQ_EN.
module serial_comparator #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start,
   input  logic mode,
   input  logic a_bit,
   input  logic b_bit,
   output logic ready,
   output logic done_tick,
   output logic agtb
`ifdef SERIAL_CMP_EQ_EN
   ,
   output logic aeqb
`endif
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]    r_state;
   logic [CW-1:0] r_count;
   logic          r_decided;
   logic          r_gt;

   logic w_diff;
   logic w_decNext;
   logic w_gtNext;

   assign w_diff    = a_bit ^ b_bit;
   assign w_decNext = r_decided | w_diff;
   assign w_gtNext  = r_decided ? r_gt : (w_diff & a_bit);

   assign ready     = (r_state == IDLE);
   assign done_tick = (r_state == DONE);

   // The MSB is resolved on the start edge itself; in signed mode a differing
   // sign bit means the operand with sign 0 (positive) is the larger one.
   // The mode input only influences that first bit, so it is consumed there.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_decided <= 1'b0;
         r_gt      <= 1'b0;
         agtb      <= 1'b0;
`ifdef SERIAL_CMP_EQ_EN
         aeqb      <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_decided <= w_diff;
                  r_gt      <= w_diff & (mode ? b_bit : a_bit);
                  r_count   <= CW'(WIDTH - 2);
                  r_state   <= SHIFT;
               end
            end
            SHIFT: begin
               r_decided <= w_decNext;
               r_gt      <= w_gtNext;
               if (r_count == '0) begin
                  r_state <= DONE;
                  agtb    <= w_gtNext;
`ifdef SERIAL_CMP_EQ_EN
                  aeqb    <= ~w_decNext;
`endif
               end else begin
                  r_count <= r_count - 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench for serial_comparator: directed test-plan cases plus
// random compares checked against an arithmetic reference model.
module tb_serial_comparator;

   localparam int WIDTH = 8;

   logic clk;
   logic reset_n;
   logic start;
   logic mode;
   logic a_bit;
   logic b_bit;
   logic ready;
   logic done_tick;
   logic agtb;
`ifdef SERIAL_CMP_EQ_EN
   logic aeqb;
`endif

   int vectors;
   int miscompares;

   serial_comparator #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .mode      (mode),
      .a_bit     (a_bit),
      .b_bit     (b_bit),
      .ready     (ready),
      .done_tick (done_tick),
      .agtb      (agtb)
`ifdef SERIAL_CMP_EQ_EN
      ,
      .aeqb      (aeqb)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain arithmetic comparison of the whole words.
   function automatic logic modelGt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic m);
      if (m) return ($signed(a) > $signed(b));
      else   return (a > b);
   endfunction

   task automatic checkOutput(input string tag, input logic observed, input logic expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, observed, expected, $time);
      end
   endtask

   // Runs one full compare: inputs driven on falling edges, outputs checked there too.
   // When interfere is set, start is pulsed and mode toggled in cycle 3.
   task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic m, input logic interfere);
      logic expGt;
      expGt = modelGt(a, b, m);
      @(negedge clk);
      checkOutput("ready_before_start", ready, 1'b1);
      start = 1'b1;
      mode  = m;
      a_bit = a[WIDTH-1];
      b_bit = b[WIDTH-1];
      for (int k = 1; k < WIDTH; k++) begin
         @(negedge clk);
         checkOutput("ready_busy", ready, 1'b0);
         checkOutput("no_early_done", done_tick, 1'b0);
         start = (interfere && k == 3);
         mode  = (interfere && k == 3) ? ~m : m;
         a_bit = a[WIDTH-1-k];
         b_bit = b[WIDTH-1-k];
      end
      @(negedge clk);
      start = 1'b0;
      a_bit = 1'b0;
      b_bit = 1'b0;
      checkOutput("done_at_width", done_tick, 1'b1);
      checkOutput("ready_in_done", ready, 1'b0);
      checkOutput("agtb", agtb, expGt);
`ifdef SERIAL_CMP_EQ_EN
      checkOutput("aeqb", aeqb, (a == b));
`endif
      @(negedge clk);
      checkOutput("done_single_pulse", done_tick, 1'b0);
      checkOutput("ready_after_done", ready, 1'b1);
      checkOutput("agtb_held", agtb, expGt);
   endtask

   initial begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      logic             rm;

      vectors     = 0;
      miscompares = 0;
      reset_n = 1'b0;
      start   = 1'b0;
      mode    = 1'b0;
      a_bit   = 1'b0;
      b_bit   = 1'b0;

      #1;
      checkOutput("reset_ready", ready, 1'b1);
      checkOutput("reset_done", done_tick, 1'b0);
      checkOutput("reset_agtb", agtb, 1'b0);
`ifdef SERIAL_CMP_EQ_EN
      checkOutput("reset_aeqb", aeqb, 1'b0);
`endif
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      applyStimulus(8'h80, 8'h7F, 1'b0, 1'b0);
      applyStimulus(8'h80, 8'h7F, 1'b1, 1'b0);
      applyStimulus(8'hFE, 8'hFD, 1'b1, 1'b0);
      applyStimulus(8'hFE, 8'hFD, 1'b0, 1'b0);
      applyStimulus(8'hFD, 8'hFE, 1'b1, 1'b0);
      applyStimulus(8'hFD, 8'hFE, 1'b0, 1'b0);
      applyStimulus(8'h5A, 8'h5A, 1'b0, 1'b0);
      applyStimulus(8'h5A, 8'h5A, 1'b1, 1'b0);
      applyStimulus(8'h5B, 8'h5A, 1'b0, 1'b0);
      applyStimulus(8'h01, 8'hFF, 1'b0, 1'b1);
      applyStimulus(8'h01, 8'hFF, 1'b1, 1'b0);

      // Establish agtb=1, then abort the next compare with reset at cycle 4.
      applyStimulus(8'h7F, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b1;
      mode  = 1'b0;
      a_bit = 1'b1;
      b_bit = 1'b0;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         start = 1'b0;
         a_bit = 1'b1;
         b_bit = 1'b0;
      end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("abort_agtb", agtb, 1'b0);
      checkOutput("abort_ready", ready, 1'b1);
      checkOutput("abort_done", done_tick, 1'b0);
      for (int k = 0; k < WIDTH; k++) begin
         @(negedge clk);
         checkOutput("abort_no_done", done_tick, 1'b0);
         if (k == 1) reset_n = 1'b1;
      end
      applyStimulus(8'h10, 8'h0F, 1'b1, 1'b0);

      for (int n = 0; n < 40; n++) begin
         ra = WIDTH'($urandom);
         rb = (n % 8 == 0) ? ra : WIDTH'($urandom);
         rm = 1'($urandom);
         applyStimulus(ra, rb, rm, 1'($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
